wavegen_sequencer: RTL

- Programmable sequencer that drives the waveform generator and amplitude scaler, replacing hand-set switches and the cascaded frequency dividers.
- Produces a single-clock sample-enable strobe at a programmable rate.
- Steps through a small program of (waveform, amplitude) entries, holding each entry for a programmable number of sample periods.
- Supports one-shot or looping playback, pause and stop.

---
 rtl/wavegen_sequencer_if.sv | 35 +++
 rtl/wavegen_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/wavegen_sequencer_if.sv
// Control, program-write and status bundle for wavegen_sequencer.
// The master side drives configuration and commands; the sequencer is the slave.
interface wavegen_sequencer_if #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DWELL_W = 16
);
  logic [DIV_W-1:0]   div_val;
  logic [DWELL_W-1:0] dwell;
  logic               prog_we;
  logic [2:0]         prog_addr;
  logic [4:0]         prog_data;
  logic [2:0]         last_step;
  logic               loop_en;
  logic               start;
  logic               pause;
  logic               stop;
  logic [2:0]         wave_sel;
  logic [1:0]         amp_sel;
  logic               sample_tick;
  logic [2:0]         step;
  logic               busy;
  logic               done;

  modport master (
    output div_val, dwell, prog_we, prog_addr, prog_data, last_step, loop_en,
           start, pause, stop,
    input  wave_sel, amp_sel, sample_tick, step, busy, done
  );

  modport slave (
    input  div_val, dwell, prog_we, prog_addr, prog_data, last_step, loop_en,
           start, pause, stop,
    output wave_sel, amp_sel, sample_tick, step, busy, done
  );
endinterface

// File: rtl/wavegen_sequencer.sv
// Programmable sequencer: sample-rate divider plus a small (wave, amplitude)
// program stepped through with a per-step dwell, with loop/pause/stop control.
module wavegen_sequencer #(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  wavegen_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_n;
  logic [2:0]         step_q, step_n, step_inc;
  logic [2:0]         wave_q, wave_n;
  logic [1:0]         amp_q, amp_n;
  logic               tick_q, tick_n;
  logic [4:0]         mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.prog_we) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign step_inc = step_q + 3'd1;

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    dwell_n = dwell_cnt;
    step_n  = step_q;
    wave_n  = wave_q;
    amp_n   = amp_q;
    tick_n  = 1'b0;
    if (bus.stop) begin
      state_n = S_IDLE;
      div_n   = '0;
      dwell_n = '0;
      step_n  = '0;
      wave_n  = '0;
      amp_n   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_n         = S_RUN;
            div_n           = '0;
            dwell_n         = '0;
            step_n          = '0;
            {wave_n, amp_n} = mem[0];
          end
        end
        S_RUN, S_PAUSE: begin
          // Release from PAUSE counts on the same edge, so only edges with
          // pause sampled high are frozen.
          if (bus.pause) begin
            state_n = S_PAUSE;
          end else begin
            state_n = S_RUN;
            if (div_cnt >= bus.div_val) begin
              tick_n = 1'b1;
              div_n  = '0;
              if (dwell_cnt >= bus.dwell) begin
                dwell_n = '0;
                if (step_q != bus.last_step) begin
                  step_n          = step_inc;
                  {wave_n, amp_n} = mem[step_inc];
                end else if (bus.loop_en) begin
                  step_n          = '0;
                  {wave_n, amp_n} = mem[0];
                end else begin
                  state_n = S_DONE;
                end
              end else begin
                dwell_n = dwell_cnt + 1'b1;
              end
            end else begin
              div_n = div_cnt + 1'b1;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      dwell_cnt <= '0;
      step_q    <= '0;
      wave_q    <= '0;
      amp_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      dwell_cnt <= dwell_n;
      step_q    <= step_n;
      wave_q    <= wave_n;
      amp_q     <= amp_n;
      tick_q    <= tick_n;
    end
  end

  assign bus.wave_sel    = wave_q;
  assign bus.amp_sel     = amp_q;
  assign bus.sample_tick = tick_q;
  assign bus.step        = step_q;
  assign bus.busy        = (state == S_RUN) || (state == S_PAUSE);
  assign bus.done        = (state == S_DONE);

endmodule
